stack_mem_ctrl: RTL and testbench

- Memory-access controller directly upstream of the 14-bit-addressable data memory block.
- Accepts PUSH/POP/LOAD/STORE requests from the stack-machine datapath and maintains the stack pointer.
- Range-checks every address, drives the memory's addr/din/wea inputs from registers, and captures the synchronous read data (douta) into a registered result with a valid pulse.
- Raises a latched exception for out-of-range addresses and for stack overflow or underflow.

---
 rtl/stack_mem_ctrl.sv | 162 ++++++++++++++++
 tb/tb_stack_mem_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_mem_ctrl.sv
// Stack/load/store access controller for the 14-bit data memory.
// Owns the stack pointer, range-checks addresses and latches exceptions.
module stack_mem_ctrl #(
    parameter logic [15:0] SP_INIT  = 16'h3FFF,
    parameter logic [15:0] SP_LIMIT = 16'h3000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  op,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] addr_in,
    input  logic [15:0] data_in,
    input  logic [15:0] mem_douta,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_din,
    output logic        mem_wea,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    output logic        done,
    output logic [15:0] sp,
    output logic        exc,
    output logic [1:0]  exc_code,
    input  logic        exc_ack
);

    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_LOAD  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;

    localparam logic [1:0] EXC_ADDR  = 2'b01;
    localparam logic [1:0] EXC_OVER  = 2'b10;
    localparam logic [1:0] EXC_UNDER = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        EXC
    } state_t;

    state_t      state;
    logic        is_read;
    logic        addr_bad;
    logic        sp_full;
    logic        sp_empty;
    logic        is_push;
    logic        is_pop;
    logic        is_load;
    logic        is_store;
    logic [15:0] sp_inc;
    logic [15:0] sp_dec;

    assign op_ready = (state == IDLE);
    assign addr_bad = |addr_in[15:14];
    assign sp_full  = (sp == SP_LIMIT - 16'd1);
    assign sp_empty = (sp == SP_INIT);
    assign sp_inc   = sp + 16'd1;
    assign sp_dec   = sp - 16'd1;

    assign is_push  = (op == OP_PUSH);
    assign is_pop   = (op == OP_POP);
    assign is_load  = (op == OP_LOAD);
    assign is_store = (op == OP_STORE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            is_read  <= 1'b0;
            sp       <= SP_INIT;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_wea  <= 1'b0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            done     <= 1'b0;
            exc      <= 1'b0;
            exc_code <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (op_valid) begin
                        unique case (1'b1)
                            is_push: begin
                                if (sp_full) begin
                                    exc      <= 1'b1;
                                    exc_code <= EXC_OVER;
                                    state    <= EXC;
                                end else begin
                                    mem_addr <= sp;
                                    mem_din  <= data_in;
                                    mem_wea  <= 1'b1;
                                    sp       <= sp_dec;
                                    is_read  <= 1'b0;
                                    state    <= ISSUE;
                                end
                            end
                            is_pop: begin
                                if (sp_empty) begin
                                    exc      <= 1'b1;
                                    exc_code <= EXC_UNDER;
                                    state    <= EXC;
                                end else begin
                                    mem_addr <= sp_inc;
                                    mem_wea  <= 1'b0;
                                    sp       <= sp_inc;
                                    is_read  <= 1'b1;
                                    state    <= ISSUE;
                                end
                            end
                            is_load, is_store: begin
                                if (addr_bad) begin
                                    exc      <= 1'b1;
                                    exc_code <= EXC_ADDR;
                                    state    <= EXC;
                                end else begin
                                    mem_addr <= addr_in;
                                    mem_wea  <= is_store;
                                    is_read  <= is_load;
                                    state    <= ISSUE;
                                    if (is_store) begin
                                        mem_din <= data_in;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                // Memory samples addr/wea on the edge that leaves ISSUE.
                ISSUE: begin
                    if (is_read) begin
                        state <= CAPTURE;
                    end else begin
                        mem_wea <= 1'b0;
                        done    <= 1'b1;
                        state   <= IDLE;
                    end
                end
                CAPTURE: begin
                    rd_data  <= mem_douta;
                    rd_valid <= 1'b1;
                    done     <= 1'b1;
                    state    <= IDLE;
                end
                EXC: begin
                    mem_wea <= 1'b0;
                    if (exc_ack) begin
                        exc      <= 1'b0;
                        exc_code <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_mem_ctrl.sv
// Bench for stack_mem_ctrl: latency-level reference model checked every
// cycle, a synchronous RAM stand-in, and directed literal checks.
module tb_stack_mem_ctrl;

    localparam int SP_INIT  = 16'h3FFF;
    localparam int SP_LIMIT = 16'h3000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [2:0]  op = 3'b000;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] addr_in = '0;
    logic [15:0] data_in = '0;
    logic [15:0] mem_douta = '0;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_wea;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic        done;
    logic [15:0] sp;
    logic        exc;
    logic [1:0]  exc_code;
    logic        exc_ack = 1'b0;

    int n_chk = 0;
    int n_fail = 0;
    bit run = 0;

    stack_mem_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .op        (op),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .addr_in   (addr_in),
        .data_in   (data_in),
        .mem_douta (mem_douta),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_wea   (mem_wea),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .done      (done),
        .sp        (sp),
        .exc       (exc),
        .exc_code  (exc_code),
        .exc_ack   (exc_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Synchronous RAM stand-in: read-before-write, 14-bit index.
    logic [15:0] ram [0:16383];
    initial begin
        for (int i = 0; i < 16384; i++) ram[i] = '0;
        forever begin
            @(posedge clk);
            mem_douta <= ram[mem_addr[13:0]];
            if (mem_wea) ram[mem_addr[13:0]] = mem_din;
        end
    end

    // Reference model: ops complete after a fixed number of edges.
    int          m_sp = SP_INIT;
    int          m_cnt = 0;
    bit          m_wr = 0;
    int          m_addr = 0;
    logic [15:0] m_din = '0;
    logic [15:0] m_rd = '0;
    bit          m_done = 0;
    bit          m_rdv = 0;
    bit          m_exc = 0;
    logic [1:0]  m_code = '0;
    logic [15:0] m_mem [int];

    initial begin
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_sp = SP_INIT; m_cnt = 0; m_wr = 0; m_addr = 0;
                m_din = '0; m_rd = '0; m_done = 0; m_rdv = 0;
                m_exc = 0; m_code = '0;
            end else begin
                m_done = 0;
                m_rdv = 0;
                if (m_exc) begin
                    if (exc_ack) begin
                        m_exc = 0;
                        m_code = '0;
                    end
                end else if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        m_done = 1;
                        if (m_wr) m_mem[m_addr] = m_din;
                        else begin
                            m_rdv = 1;
                            m_rd = m_mem.exists(m_addr) ? m_mem[m_addr] : 16'h0;
                        end
                    end
                end else if (op_valid) begin
                    case (op)
                        3'd1: if (m_sp == SP_LIMIT - 1) begin
                                m_exc = 1; m_code = 2'b10;
                            end else begin
                                m_addr = m_sp; m_din = data_in; m_wr = 1;
                                m_sp = m_sp - 1; m_cnt = 1;
                            end
                        3'd2: if (m_sp == SP_INIT) begin
                                m_exc = 1; m_code = 2'b11;
                            end else begin
                                m_sp = m_sp + 1; m_addr = m_sp;
                                m_wr = 0; m_cnt = 2;
                            end
                        3'd3, 3'd4: if (addr_in >= 16'h4000) begin
                                m_exc = 1; m_code = 2'b01;
                            end else begin
                                m_addr = addr_in; m_wr = (op == 3'd4);
                                m_din = data_in; m_cnt = m_wr ? 1 : 2;
                            end
                        default: ;
                    endcase
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("op_ready", 32'(op_ready), 32'(!m_exc && m_cnt == 0));
            chk("sp", 32'(sp), 32'(m_sp));
            chk("exc", 32'(exc), 32'(m_exc));
            chk("exc_code", 32'(exc_code), 32'(m_code));
            chk("done", 32'(done), 32'(m_done));
            chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
            chk("rd_data", 32'(rd_data), 32'(m_rd));
            chk("mem_wea", 32'(mem_wea), 32'(m_wr && m_cnt == 1));
            if (m_cnt > 0) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
            if (m_wr && m_cnt == 1) chk("mem_din", 32'(mem_din), 32'(m_din));
        end
    end

    task automatic do_op(input logic [2:0] o, input logic [15:0] a,
                         input logic [15:0] d);
        int n = 0;
        while (!op_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_wait", 32'(op_ready), 32'd1);
        op = o; addr_in = a; data_in = d; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        op = 3'($urandom_range(0, 7));
        addr_in = 16'($urandom);
        data_in = 16'($urandom);
        n = 0;
        while (!done && !exc && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk("op_complete", 32'(done || exc), 32'd1);
    endtask

    task automatic ack();
        exc_ack = 1'b1;
        @(posedge clk); #1;
        exc_ack = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        run = 1;
        @(negedge clk);
        chk("rst_sp", 32'(sp), 32'h3FFF);
        chk("rst_ready", 32'(op_ready), 32'd1);
        chk("rst_exc", 32'(exc), 32'd0);
        chk("rst_wea", 32'(mem_wea), 32'd0);
        chk("rst_rdv", 32'(rd_valid), 32'd0);
        @(posedge clk); #1;

        do_op(3'd1, 16'h0, 16'd100);
        do_op(3'd1, 16'h0, 16'd1000);
        @(posedge clk); #1;
        chk("ram_3fff", 32'(ram[14'h3FFF]), 32'd100);
        chk("ram_3ffe", 32'(ram[14'h3FFE]), 32'd1000);
        do_op(3'd2, 16'h0, 16'h0);
        chk("pop1", 32'(rd_data), 32'd1000);
        do_op(3'd2, 16'h0, 16'h0);
        chk("pop2", 32'(rd_data), 32'd100);
        chk("pop_sp", 32'(sp), 32'h3FFF);

        do_op(3'd4, 16'd2, 16'd10000);
        do_op(3'd3, 16'd2, 16'h0);
        chk("load2", 32'(rd_data), 32'd10000);

        // Illegal opcodes and a stray ack in IDLE do nothing.
        op = 3'd7; op_valid = 1'b1; exc_ack = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0; exc_ack = 1'b0;
        @(posedge clk); #1;
        chk("nop_done", 32'(done), 32'd0);

        foreach (ram[i]) if (i == 0) begin end
        begin
            logic [15:0] bad [3];
            bad[0] = 16'h4000; bad[1] = 16'hC000; bad[2] = 16'h8000;
            for (int i = 0; i < 3; i++) begin
                do_op(3'd3, bad[i], 16'h0);
                chk("bad_code", 32'(exc_code), 32'd1);
                repeat (2) @(posedge clk);
                #1 chk("bad_ready", 32'(op_ready), 32'd0);
                ack();
            end
        end
        do_op(3'd4, 16'h4000, 16'h5555);
        chk("bad_st_code", 32'(exc_code), 32'd1);
        ack();

        do_op(3'd2, 16'h0, 16'h0);
        chk("under_code", 32'(exc_code), 32'd3);
        chk("under_sp", 32'(sp), 32'h3FFF);
        ack();

        for (int i = 0; i < 4096; i++) do_op(3'd1, 16'h0, 16'(i + 7));
        chk("full_sp", 32'(sp), 32'h2FFF);
        do_op(3'd1, 16'h0, 16'hDEAD);
        chk("over_code", 32'(exc_code), 32'd2);
        chk("over_sp", 32'(sp), 32'h2FFF);
        ack();
        do_op(3'd2, 16'h0, 16'h0);
        chk("top_pop", 32'(rd_data), 32'd4102);

        // Reset while a STORE is in ISSUE drops the write.
        do_op(3'd4, 16'd5, 16'h1111);
        @(posedge clk); #1;
        op = 3'd4; addr_in = 16'd5; data_in = 16'hBEEF; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("abort_wea", 32'(mem_wea), 32'd0);
        chk("abort_sp", 32'(sp), 32'h3FFF);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        chk("abort_ram", 32'(ram[5]), 32'h1111);
        do_op(3'd3, 16'd5, 16'h0);
        chk("abort_load", 32'(rd_data), 32'h1111);

        repeat (3) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
